// File: rtl/cam_capture_rgb444.sv
// OV7670-style capture: packs RGB444 byte pairs into 12-bit pixels
// and writes them linearly into a H_PIXELS x V_LINES frame buffer.
module cam_capture_rgb444 #(
   parameter int H_PIXELS = 160,
   parameter int V_LINES  = 120,
   parameter int AW       = 15,
   parameter int DW       = 12
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          CAM_vsync,
   input  logic          CAM_href,
   input  logic [7:0]    CAM_px_data,
   output logic          DP_RAM_regW,
   output logic [AW-1:0] DP_RAM_addr_in,
   output logic [DW-1:0] DP_RAM_data_in,
   output logic          frame_done,
   output logic          line_err
);

   localparam int CW = $clog2(H_PIXELS + 1);
   localparam int RW = $clog2(V_LINES + 1);

   localparam logic [CW-1:0] H_MAX  = CW'(H_PIXELS);
   localparam logic [RW-1:0] V_MAX  = RW'(V_LINES);
   localparam logic [RW-1:0] V_LAST = RW'(V_LINES - 1);
   localparam logic [AW-1:0] H_STEP = AW'(H_PIXELS);

   typedef enum logic [1:0] {
      WAIT_FRAME,
      BYTE_HI,
      BYTE_LO
   } state_t;

   state_t        state_q;
   logic          vsync_q;
   logic          href_q;
   logic [CW-1:0] col_q;
   logic [RW-1:0] row_q;
   logic [AW-1:0] base_q;
   logic [3:0]    r_hold_q;
   logic          regw_q;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] data_q;
   logic          done_q;
   logic          lerr_q;

   logic vs_fall;
   logic vs_rise;
   logic href_fall;
   logic pix_ok;
   logic line_adv;
   logic last_line;
   logic capturing;

   assign vs_fall   = vsync_q & ~CAM_vsync;
   assign vs_rise   = ~vsync_q & CAM_vsync;
   assign href_fall = href_q & ~CAM_href;
   assign pix_ok    = (col_q < H_MAX) && (row_q < V_MAX);
   assign line_adv  = href_fall && (col_q != '0);
   assign last_line = (row_q == V_LAST);
   assign capturing = (state_q != WAIT_FRAME);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= WAIT_FRAME;
         vsync_q  <= 1'b0;
         href_q   <= 1'b0;
         col_q    <= '0;
         row_q    <= '0;
         base_q   <= '0;
         r_hold_q <= '0;
         regw_q   <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
         done_q   <= 1'b0;
         lerr_q   <= 1'b0;
      end else begin
         vsync_q <= CAM_vsync;
         href_q  <= CAM_href;
         regw_q  <= 1'b0;
         done_q  <= 1'b0;
         lerr_q  <= 1'b0;

         unique case (state_q)
            WAIT_FRAME: begin
               if (vs_fall) begin
                  state_q <= BYTE_HI;
                  col_q   <= '0;
                  row_q   <= '0;
                  base_q  <= '0;
               end
            end
            BYTE_HI: begin
               if (CAM_href) begin
                  r_hold_q <= CAM_px_data[3:0];
                  state_q  <= BYTE_LO;
               end
            end
            BYTE_LO: begin
               if (CAM_href) begin
                  if (pix_ok) begin
                     regw_q <= 1'b1;
                     addr_q <= base_q + AW'(col_q);
                     data_q <= DW'({r_hold_q,
                                    CAM_px_data[7:4],
                                    CAM_px_data[3:0]});
                     col_q  <= col_q + 1'b1;
                  end
               end else begin
                  // an aborting vsync swallows the half pixel silently
                  lerr_q <= ~CAM_vsync;
               end
               state_q <= BYTE_HI;
            end
            default: state_q <= WAIT_FRAME;
         endcase

         if (capturing) begin
            if (line_adv) begin
               col_q  <= '0;
               row_q  <= row_q + 1'b1;
               base_q <= base_q + H_STEP;
               if (last_line) begin
                  done_q  <= 1'b1;
                  state_q <= WAIT_FRAME;
               end
            end
            if (vs_rise) begin
               state_q <= WAIT_FRAME;
            end
         end
      end
   end

   assign DP_RAM_regW    = regw_q;
   assign DP_RAM_addr_in = addr_q;
   assign DP_RAM_data_in = data_q;
   assign frame_done     = done_q;
   assign line_err       = lerr_q;

endmodule

// File: tb/tb_cam_capture_rgb444.sv
// Bench for cam_capture_rgb444: directed frames with random bytes,
// compared against a line-level model of the expected RAM writes.
module tb_cam_capture_rgb444;

   localparam int H  = 160;
   localparam int V  = 120;
   localparam int AW = 15;
   localparam int DW = 12;

   logic          clk = 1'b0;
   logic          rst;
   logic          CAM_vsync;
   logic          CAM_href;
   logic [7:0]    CAM_px_data;
   logic          DP_RAM_regW;
   logic [AW-1:0] DP_RAM_addr_in;
   logic [DW-1:0] DP_RAM_data_in;
   logic          frame_done;
   logic          line_err;

   int n_vec     = 0;
   int n_err     = 0;
   int n_strobe  = 0;
   int n_done    = 0;
   int n_lerr    = 0;
   int last_addr = -1;
   int tot_done  = 0;
   int tot_err   = 0;
   bit m_active  = 1'b0;
   int m_row     = 0;
   bit l_err;
   bit l_done;

   typedef struct {
      int a;
      int d;
   } wr_t;

   wr_t        exp_q[$];
   wr_t        mon_e;
   logic [7:0] lb[$];

   cam_capture_rgb444 #(
      .H_PIXELS(H), .V_LINES(V), .AW(AW), .DW(DW)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .CAM_vsync     (CAM_vsync),
      .CAM_href      (CAM_href),
      .CAM_px_data   (CAM_px_data),
      .DP_RAM_regW   (DP_RAM_regW),
      .DP_RAM_addr_in(DP_RAM_addr_in),
      .DP_RAM_data_in(DP_RAM_data_in),
      .frame_done    (frame_done),
      .line_err      (line_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (DP_RAM_regW === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("stray_strobe", 32'(DP_RAM_regW), 0);
         end else begin
            mon_e = exp_q.pop_front();
            chk("waddr", 32'(DP_RAM_addr_in), mon_e.a);
            chk("wdata", 32'(DP_RAM_data_in), mon_e.d);
         end
         n_strobe++;
         last_addr = int'(DP_RAM_addr_in);
      end
      if (frame_done === 1'b1) n_done++;
      if (line_err === 1'b1) n_lerr++;
   end

   // model: one call per line, mode 0 normal, 1 reset at end,
   // 2 vsync rises with the last byte
   task automatic model_line(input int mode);
      int  n  = lb.size();
      int  np = n / 2;
      wr_t w;
      l_err  = 1'b0;
      l_done = 1'b0;
      if (!m_active) return;
      for (int p = 0; p < np; p++) begin
         if (p < H && m_row < V) begin
            w.a = m_row * H + p;
            w.d = int'({lb[2*p][3:0], lb[2*p+1]});
            exp_q.push_back(w);
         end
      end
      if (mode != 0) begin
         m_active = 1'b0;
         return;
      end
      l_err = (n % 2) == 1;
      if (l_err) tot_err++;
      if (np > 0) begin
         m_row++;
         if (m_row == V) begin
            l_done   = 1'b1;
            m_active = 1'b0;
            tot_done++;
         end
      end
   endtask

   task automatic cyc(input logic vs, input logic hr,
                      input logic [7:0] d);
      CAM_vsync   = vs;
      CAM_href    = hr;
      CAM_px_data = d;
      @(posedge clk);
      #1;
   endtask

   task automatic vsync_pulse(input int k);
      for (int i = 0; i < k; i++)
         cyc(1'b1, 1'($urandom_range(0, 1)), 8'($urandom));
      cyc(1'b1, 1'b0, 8'h00);
      cyc(1'b0, 1'b0, 8'h00);
      cyc(1'b0, 1'b0, 8'h00);
      m_active = 1'b1;
      m_row    = 0;
   endtask

   task automatic line_out(input int mode);
      int n   = lb.size();
      bit act = m_active;
      bit vsl;
      model_line(mode);
      for (int i = 0; i < n; i++) begin
         vsl = (mode == 2) && (i == n - 1);
         cyc(vsl, 1'b1, lb[i]);
         if (i == 0) begin
            @(negedge clk);
            chk("strobe_b0", 32'(DP_RAM_regW), 0);
         end else if (i == 1) begin
            @(negedge clk);
            chk("strobe_b1", 32'(DP_RAM_regW), 32'(act));
            if (act)
               chk("pix0", 32'(DP_RAM_data_in),
                   32'({lb[0][3:0], lb[1]}));
         end
      end
      if (mode == 1) begin
         rst = 1'b1;
         cyc(1'b0, 1'b1, 8'h77);
         rst = 1'b0;
         @(negedge clk);
         chk("rst_outs", 32'({DP_RAM_regW, DP_RAM_addr_in,
                              DP_RAM_data_in, frame_done,
                              line_err}), 0);
      end else begin
         cyc(mode == 2, 1'b0, 8'h00);
         @(negedge clk);
         chk("line_err", 32'(line_err), 32'(l_err));
         chk("frame_done", 32'(frame_done), 32'(l_done));
      end
      repeat (3) cyc(mode == 2, 1'b0, 8'h00);
   endtask

   task automatic rand_line(input int n);
      lb.delete();
      for (int i = 0; i < n; i++) lb.push_back(8'($urandom));
   endtask

   initial begin
      int s0;
      rst         = 1'b1;
      CAM_vsync   = 1'b0;
      CAM_href    = 1'b0;
      CAM_px_data = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      chk("reset_outs", 32'({DP_RAM_regW, DP_RAM_addr_in,
                             DP_RAM_data_in, frame_done,
                             line_err}), 0);
      rst = 1'b0;
      cyc(1'b0, 1'b0, 8'h00);

      // no vsync edge yet: bytes must be ignored
      rand_line(20);
      line_out(0);

      // full frame of 0x00/0x0F
      vsync_pulse(648);
      s0 = n_strobe;
      for (int l = 0; l < V; l++) begin
         lb.delete();
         for (int i = 0; i < 2 * H; i++)
            lb.push_back((i % 2) ? 8'h0F : 8'h00);
         line_out(0);
      end
      chk("frame_strobes", n_strobe - s0, H * V);
      chk("frame_last", last_addr, 32'h4AFF);
      chk("frame_done_cnt", n_done, 1);
      chk("frame_lerr_cnt", n_lerr, 0);

      // 50 long lines, then vsync aborts the frame
      vsync_pulse(8);
      for (int l = 0; l < 50; l++) begin
         rand_line(320 + $urandom_range(0, 2));
         if (l == 0) begin
            lb[0] = 8'hA5;
            lb[1] = 8'h3C;
         end
         line_out(0);
      end
      chk("abort_last", last_addr, 7999);
      vsync_pulse(8);
      chk("abort_done_cnt", n_done, tot_done);

      // reset in the middle of line 10
      for (int l = 0; l < 10; l++) begin
         rand_line($urandom_range(2, 60));
         line_out(0);
      end
      rand_line(101);
      line_out(1);
      rand_line(40);
      line_out(0);

      // short random lines until the frame completes
      vsync_pulse(8);
      for (int it = 0; it < 3000 && m_active; it++) begin
         rand_line($urandom_range(0, 30));
         line_out(0);
      end
      chk("short_done", 32'(m_active), 0);
      rand_line(30);
      line_out(0);

      // vsync rises with the last byte of the final line
      vsync_pulse(8);
      for (int it = 0; it < 3000 && m_row < V - 1; it++) begin
         rand_line($urandom_range(2, 20));
         line_out(0);
      end
      rand_line(6);
      line_out(2);
      vsync_pulse(8);
      rand_line(20);
      line_out(0);

      chk("exp_q_empty", exp_q.size(), 0);
      chk("done_total", n_done, tot_done);
      chk("lerr_total", n_lerr, tot_err);
      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_err);
      $finish;
   end

endmodule
